button_group_ctl: RTL and testbench
===================================

// Module: button_group_ctl
// PURPOSE
// Parametrised group of N on-screen buttons on a row or column. Per button: hit test, hover/pressed highlight,
// bordered rectangle drawn onto the VGA bus. Click = press AND release inside the same button.
// Emits a one-cycle click pulse plus index. Sits in the menu/board pipeline; replaces a chain of single buttons.
// PARAMETERS
// N_BUTTONS    4        number of buttons, 1..16
// VERTICAL     0        0: buttons left->right; 1: top->bottom
// X_POS        50       x of button 0 top-left pixel
// Y_POS        50       y of button 0 top-left pixel
// BTN_WIDTH    200      button width in pixels
// BTN_HEIGHT   60       button height in pixels
// GAP          20       pixels between adjacent buttons
// BORDER       2        border thickness in pixels, 0 = none
// IDLE_COLOR   12'h8_8_8  fill when not hovered
// HOVER_COLOR  12'hB_B_B  fill when hovered and not armed
// PRESS_COLOR  12'h4_4_F  fill when armed and pointer over it
// BORDER_COLOR 12'h0_0_0  border colour
// PORTS
// clk          in   1              pixel clock
// rst          in   1              asynchronous, active-high reset
// enable       in   1              group active; 0 = inert, video pass-through
// mouse_left   in   1              left button level
// mouse_xpos   in   12             pointer x
// mouse_ypos   in   12             pointer y
// vga_in       in   `VGA_BUS_SIZE  incoming VGA bus (`_vga_macros.vh` layout)
// btn_click    out  N_BUTTONS      one-hot click pulse, one cycle
// click_idx    out  IDX_W          index of last click, IDX_W = N_BUTTONS>1 ? $clog2(N_BUTTONS) : 1
// hover_valid  out  1              pointer over some button
// hover_idx    out  IDX_W          index of hovered button (0 when hover_valid=0)
// vga_out      out  `VGA_BUS_SIZE  outgoing VGA bus
// BEHAVIOUR
// - One clock, one reset. Async rst: all outputs and state 0. vga_out = 0. FSM -> IDLE.
// - Geometry: button k origin = POS + k*(SIZE+GAP) on the layout axis; other axis fixed.
//   Inside = x in [x_k, x_k+BTN_WIDTH-1] and y in [y_k, y_k+BTN_HEIGHT-1]. Gap pixels hit nothing.
//   All sums in 12-bit unsigned; parameters chosen so no overflow.
// - Stage 1 (registered): left_q, left_qq, hover_valid, hover_idx from pointer inputs.
// - FSM runs on stage-1 values; press = left_q & ~left_qq; release = ~left_q & left_qq.
//   IDLE:  press & hover_valid -> ARMED(arm_idx=hover_idx). press & ~hover_valid -> BLOCKED.
//   ARMED: release & hover_valid & hover_idx==arm_idx -> btn_click[arm_idx]=1 for 1 cycle,
//          click_idx<=arm_idx -> IDLE. release elsewhere -> IDLE, no click.
//          Dragging out and back in while held keeps the button ARMED.
//   BLOCKED: press began outside all buttons. release -> IDLE, never clicks.
// - Latency: mouse_left first sampled low at edge t -> btn_click high in the cycle after edge t+2.
// - click_idx holds its value until the next click. btn_click is never multi-hot.
// - enable=0: FSM forced IDLE next edge; btn_click=0; hover_valid=0; hover_idx=0; vga_out=vga_in delayed 1.
//   Dropping enable while ARMED cancels the click.
//   Raising enable with mouse_left already high: no press edge -> no arm until re-press.
// - Video: vga_out = vga_in delayed exactly 1 cycle (all fields).
//   Inside button k and not blanking: rgb replaced.
//   Outer BORDER pixels of the rectangle -> BORDER_COLOR.
//   Otherwise fill = PRESS_COLOR if ARMED & arm_idx==k & hover on k; else HOVER_COLOR if hovered; else IDLE_COLOR.
//   Colour decisions use the FSM/hover state registered at that edge.
// TESTING
// - N=4,horiz, defaults. Press at (60,60), release at (60,60) -> btn_click=4'b0001 1 cycle, click_idx=0.
// - Press at (320,70) [btn1], drag to (600,70) [btn2], release -> no btn_click, FSM IDLE.
// - Press at (260,70) [gap], move to (60,60), release -> no click (BLOCKED path).
// - Press in btn3 (x=710), drop enable before release -> no click; vga_out==vga_in delayed 1; hover_valid=0.
// - Raster scan over btn0 with pointer at (60,60) idle: pixel (50,50)=BORDER_COLOR, (100,80)=HOVER_COLOR,
//   (251,80) unchanged; hold left -> (100,80)=PRESS_COLOR. VERTICAL=1: same tests on y axis.
// - Assert rst while ARMED in btn2 -> all outputs 0 at once; release after reset -> no click.

Source files
------------

// File: rtl/button_group_ctl_if.sv
// Port bundle for button_group_ctl: pointer, enable, VGA streams and click/hover results.
// VGA bus layout (38 bits, MSB first): vcount[10:0], vsync, vblnk, hcount[10:0], hsync, hblnk, rgb[11:0].
interface button_group_ctl_if #(
  parameter int N_BUTTONS = 4
) ();
  localparam int IDX_W        = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1;
  localparam int VGA_BUS_SIZE = 38;

  logic                    enable;
  logic                    mouse_left;
  logic [11:0]             mouse_xpos;
  logic [11:0]             mouse_ypos;
  logic [VGA_BUS_SIZE-1:0] vga_in;
  logic [N_BUTTONS-1:0]    btn_click;
  logic [IDX_W-1:0]        click_idx;
  logic                    hover_valid;
  logic [IDX_W-1:0]        hover_idx;
  logic [VGA_BUS_SIZE-1:0] vga_out;

  modport slave (
    input  enable, mouse_left, mouse_xpos, mouse_ypos, vga_in,
    output btn_click, click_idx, hover_valid, hover_idx, vga_out
  );

  modport master (
    output enable, mouse_left, mouse_xpos, mouse_ypos, vga_in,
    input  btn_click, click_idx, hover_valid, hover_idx, vga_out
  );
endinterface

// File: rtl/button_group_ctl.sv
// Row/column of N on-screen buttons: hit test, press/release click FSM, and
// bordered, state-coloured rectangles overlaid on a 1-cycle-delayed VGA stream.
module button_group_ctl #(
  parameter int          N_BUTTONS    = 4,
  parameter int          VERTICAL     = 0,
  parameter int          X_POS        = 50,
  parameter int          Y_POS        = 50,
  parameter int          BTN_WIDTH    = 200,
  parameter int          BTN_HEIGHT   = 60,
  parameter int          GAP          = 20,
  parameter int          BORDER       = 2,
  parameter logic [11:0] IDLE_COLOR   = 12'h888,
  parameter logic [11:0] HOVER_COLOR  = 12'hBBB,
  parameter logic [11:0] PRESS_COLOR  = 12'h44F,
  parameter logic [11:0] BORDER_COLOR = 12'h000
) (
  input logic               clk,
  input logic               rst,
  button_group_ctl_if.slave bus
);
  localparam int IDX_W = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1;
  localparam int VGA_W = 38;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_BLOCKED = 2'd2
  } state_t;

  function automatic logic [11:0] org_x(input int k);
    return 12'(X_POS + ((VERTICAL == 0) ? k * (BTN_WIDTH + GAP) : 0));
  endfunction

  function automatic logic [11:0] org_y(input int k);
    return 12'(Y_POS + ((VERTICAL != 0) ? k * (BTN_HEIGHT + GAP) : 0));
  endfunction

  function automatic logic in_btn(input int k, input logic [11:0] x, input logic [11:0] y);
    logic [11:0] x0;
    logic [11:0] y0;
    x0 = org_x(k);
    y0 = org_y(k);
    return (x >= x0) && (x <= 12'(x0 + BTN_WIDTH - 1)) &&
           (y >= y0) && (y <= 12'(y0 + BTN_HEIGHT - 1));
  endfunction

  // Only meaningful for a pixel already known to be inside button k.
  function automatic logic on_border(input int k, input logic [11:0] x, input logic [11:0] y);
    logic [11:0] x0;
    logic [11:0] y0;
    x0 = org_x(k);
    y0 = org_y(k);
    return (x < 12'(x0 + BORDER)) || (x > 12'(x0 + BTN_WIDTH - 1 - BORDER)) ||
           (y < 12'(y0 + BORDER)) || (y > 12'(y0 + BTN_HEIGHT - 1 - BORDER));
  endfunction

  // ---------------- stage 1: pointer sampling and hit test ----------------
  logic             hit_valid;
  logic [IDX_W-1:0] hit_idx;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    hit_valid = 1'b0;
    hit_idx   = '0;
    for (int k = 0; k < N_BUTTONS; k++) begin
      if (in_btn(k, bus.mouse_xpos, bus.mouse_ypos)) begin
        hit_valid = 1'b1;
        hit_idx   = IDX_W'(k);
      end
    end
  end

  logic             left_q, left_qq, primed;
  logic             hover_valid_q;
  logic [IDX_W-1:0] hover_idx_q;

  // primed stays low after reset until the button is seen released, so a
  // button held through reset cannot produce a press edge.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_q        <= 1'b0;
      left_qq       <= 1'b0;
      primed        <= 1'b0;
      hover_valid_q <= 1'b0;
      hover_idx_q   <= '0;
    end else begin
      left_q        <= bus.mouse_left;
      left_qq       <= left_q;
      primed        <= primed | ~bus.mouse_left;
      hover_valid_q <= bus.enable & hit_valid;
      hover_idx_q   <= (bus.enable && hit_valid) ? hit_idx : '0;
    end
  end

  logic press, release_ev;
  assign press      = left_q & ~left_qq & primed;
  assign release_ev = ~left_q & left_qq;

  // ---------------- click FSM ----------------
  state_t           state, state_d;
  logic [IDX_W-1:0] arm_idx, arm_idx_d;
  logic             fire_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      arm_idx <= '0;
    end else begin
      state   <= state_d;
      arm_idx <= arm_idx_d;
    end
  end

  always_comb begin
    state_d   = state;
    arm_idx_d = arm_idx;
    fire_d    = 1'b0;
    if (!bus.enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (press) begin
            if (hover_valid_q) begin
              state_d   = S_ARMED;
              arm_idx_d = hover_idx_q;
            end else begin
              state_d = S_BLOCKED;
            end
          end
        end
        S_ARMED: begin
          if (release_ev) begin
            fire_d  = hover_valid_q && (hover_idx_q == arm_idx);
            state_d = S_IDLE;
          end
        end
        S_BLOCKED: begin
          if (release_ev) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------- video overlay ----------------
  logic [11:0]      pix_x, pix_y;
  logic             blank;
  logic [11:0]      rgb_d;
  logic [VGA_W-1:0] vga_d;

  always_comb begin
    pix_x = {1'b0, bus.vga_in[24:14]};
    pix_y = {1'b0, bus.vga_in[37:27]};
    blank = bus.vga_in[12] | bus.vga_in[25];
    rgb_d = bus.vga_in[11:0];
    if (bus.enable && !blank) begin
      for (int k = 0; k < N_BUTTONS; k++) begin
        if (in_btn(k, pix_x, pix_y)) begin
          if (on_border(k, pix_x, pix_y))
            rgb_d = BORDER_COLOR;
          else if (state == S_ARMED && arm_idx == IDX_W'(k) &&
                   hover_valid_q && hover_idx_q == IDX_W'(k))
            rgb_d = PRESS_COLOR;
          else if (hover_valid_q && hover_idx_q == IDX_W'(k))
            rgb_d = HOVER_COLOR;
          else
            rgb_d = IDLE_COLOR;
        end
      end
    end
    vga_d = {bus.vga_in[37:12], rgb_d};
  end

  // ---------------- output registers ----------------
  logic                 fire_q;
  logic [IDX_W-1:0]     fire_idx_q;
  logic [N_BUTTONS-1:0] click_onehot;
  logic [N_BUTTONS-1:0] btn_click_q;
  logic [IDX_W-1:0]     click_idx_q;
  logic [VGA_W-1:0]     vga_out_q;

  always_comb begin
    click_onehot = '0;
    for (int k = 0; k < N_BUTTONS; k++)
      click_onehot[k] = (fire_idx_q == IDX_W'(k));
  end

  // The click decision is registered once more before reaching the ports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fire_q      <= 1'b0;
      fire_idx_q  <= '0;
      btn_click_q <= '0;
      click_idx_q <= '0;
      vga_out_q   <= '0;
    end else begin
      fire_q     <= fire_d;
      fire_idx_q <= arm_idx;
      vga_out_q  <= vga_d;
      if (fire_q && bus.enable) begin
        btn_click_q <= click_onehot;
        click_idx_q <= fire_idx_q;
      end else begin
        btn_click_q <= '0;
      end
    end
  end

  assign bus.btn_click   = btn_click_q;
  assign bus.click_idx   = click_idx_q;
  assign bus.hover_valid = hover_valid_q;
  assign bus.hover_idx   = hover_idx_q;
  assign bus.vga_out     = vga_out_q;
endmodule

// File: tb/tb_button_group_ctl.sv
// Directed bench for button_group_ctl: a horizontal and a vertical instance share
// the same pointer/video stimulus and are checked against hand-computed values.
module tb_button_group_ctl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable;
  logic        mouse_left;
  logic [11:0] mouse_x, mouse_y;
  logic [37:0] vga_in;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  button_group_ctl_if #(.N_BUTTONS(4)) h_if ();
  button_group_ctl_if #(.N_BUTTONS(4)) v_if ();

  assign h_if.enable = enable;     assign v_if.enable = enable;
  assign h_if.mouse_left = mouse_left; assign v_if.mouse_left = mouse_left;
  assign h_if.mouse_xpos = mouse_x; assign v_if.mouse_xpos = mouse_x;
  assign h_if.mouse_ypos = mouse_y; assign v_if.mouse_ypos = mouse_y;
  assign h_if.vga_in = vga_in;     assign v_if.vga_in = vga_in;

  button_group_ctl #(.N_BUTTONS(4), .VERTICAL(0)) u_h (.clk(clk), .rst(rst), .bus(h_if));
  button_group_ctl #(.N_BUTTONS(4), .VERTICAL(1)) u_v (.clk(clk), .rst(rst), .bus(v_if));

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        hv;
    logic [1:0]  hi;
    logic        vv;
    logic [1:0]  vi;
  } hover_vec_t;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        blank;
    logic [11:0] h_rgb;
    logic [11:0] v_rgb;
  } pix_vec_t;

  hover_vec_t hv_tab[17];
  pix_vec_t   px_tab[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] mk_pix(input logic [10:0] x, input logic [10:0] y, input logic blank);
    return {y, 1'b1, 1'b0, x, 1'b0, blank, 12'h5A3};
  endfunction

  task automatic show_pix(input string name, input logic [10:0] x, input logic [10:0] y,
                          input logic blank, input logic [11:0] h_rgb, input logic [11:0] v_rgb);
    logic [37:0] p;
    p      = mk_pix(x, y, blank);
    vga_in = p;
    tick();
    check({name, "_h"}, 64'(h_if.vga_out), 64'({p[37:12], h_rgb}));
    check({name, "_v"}, 64'(v_if.vga_out), 64'({p[37:12], v_rgb}));
  endtask

  task automatic press_at(input logic [11:0] x, input logic [11:0] y);
    mouse_x = x;
    mouse_y = y;
    repeat (2) tick();
    mouse_left = 1'b1;
    repeat (3) tick();
  endtask

  task automatic move_to(input logic [11:0] x, input logic [11:0] y);
    mouse_x = x;
    mouse_y = y;
    repeat (3) tick();
  endtask

  // Releases the button and records which click lines pulsed and for how many cycles.
  task automatic expect_release(input string name, input logic [3:0] h_exp, input logic [3:0] v_exp);
    logic [3:0] hs, vs;
    int hn, vn;
    hs = '0; vs = '0; hn = 0; vn = 0;
    mouse_left = 1'b0;
    repeat (8) begin
      tick();
      hs |= h_if.btn_click;
      vs |= v_if.btn_click;
      if (h_if.btn_click != 4'b0) hn++;
      if (v_if.btn_click != 4'b0) vn++;
    end
    check({name, "_click_h"}, 64'(hs), 64'(h_exp));
    check({name, "_click_v"}, 64'(vs), 64'(v_exp));
    check({name, "_cycles_h"}, 64'(hn), (h_exp != 4'b0) ? 64'd1 : 64'd0);
    check({name, "_cycles_v"}, 64'(vn), (v_exp != 4'b0) ? 64'd1 : 64'd0);
  endtask

  initial begin
    hv_tab = '{
      '{12'd60,  12'd60,  1'b1, 2'd0, 1'b1, 2'd0},
      '{12'd49,  12'd60,  1'b0, 2'd0, 1'b0, 2'd0},
      '{12'd50,  12'd50,  1'b1, 2'd0, 1'b1, 2'd0},
      '{12'd249, 12'd109, 1'b1, 2'd0, 1'b1, 2'd0},
      '{12'd250, 12'd60,  1'b0, 2'd0, 1'b0, 2'd0},
      '{12'd269, 12'd60,  1'b0, 2'd0, 1'b0, 2'd0},
      '{12'd270, 12'd60,  1'b1, 2'd1, 1'b0, 2'd0},
      '{12'd320, 12'd70,  1'b1, 2'd1, 1'b0, 2'd0},
      '{12'd600, 12'd70,  1'b1, 2'd2, 1'b0, 2'd0},
      '{12'd710, 12'd70,  1'b1, 2'd3, 1'b0, 2'd0},
      '{12'd909, 12'd109, 1'b1, 2'd3, 1'b0, 2'd0},
      '{12'd910, 12'd70,  1'b0, 2'd0, 1'b0, 2'd0},
      '{12'd60,  12'd110, 1'b0, 2'd0, 1'b0, 2'd0},
      '{12'd60,  12'd130, 1'b0, 2'd0, 1'b1, 2'd1},
      '{12'd60,  12'd300, 1'b0, 2'd0, 1'b1, 2'd3},
      '{12'd60,  12'd350, 1'b0, 2'd0, 1'b0, 2'd0},
      '{12'd320, 12'd110, 1'b0, 2'd0, 1'b0, 2'd0}
    };
    // Pointer idles at (60,60): button 0 hovered in both layouts.
    px_tab = '{
      '{11'd50,  11'd50,  1'b0, 12'h000, 12'h000},
      '{11'd51,  11'd51,  1'b0, 12'h000, 12'h000},
      '{11'd52,  11'd52,  1'b0, 12'hBBB, 12'hBBB},
      '{11'd100, 11'd80,  1'b0, 12'hBBB, 12'hBBB},
      '{11'd249, 11'd80,  1'b0, 12'h000, 12'h000},
      '{11'd250, 11'd80,  1'b0, 12'h5A3, 12'h5A3},
      '{11'd251, 11'd80,  1'b0, 12'h5A3, 12'h5A3},
      '{11'd270, 11'd80,  1'b0, 12'h000, 12'h5A3},
      '{11'd300, 11'd80,  1'b0, 12'h888, 12'h5A3},
      '{11'd100, 11'd109, 1'b0, 12'h000, 12'h000},
      '{11'd100, 11'd110, 1'b0, 12'h5A3, 12'h5A3},
      '{11'd100, 11'd130, 1'b0, 12'h5A3, 12'h000},
      '{11'd100, 11'd140, 1'b0, 12'h5A3, 12'h888},
      '{11'd100, 11'd80,  1'b1, 12'h5A3, 12'h5A3},
      '{11'd49,  11'd80,  1'b0, 12'h5A3, 12'h5A3},
      '{11'd909, 11'd80,  1'b0, 12'h000, 12'h5A3},
      '{11'd800, 11'd80,  1'b0, 12'h888, 12'h5A3}
    };

    enable     = 1'b1;
    mouse_left = 1'b0;
    mouse_x    = 12'd0;
    mouse_y    = 12'd0;
    vga_in     = mk_pix(11'd100, 11'd80, 1'b0);
    rst        = 1'b1;
    repeat (3) tick();
    check("rst_vga_h",   64'(h_if.vga_out),     64'd0);
    check("rst_vga_v",   64'(v_if.vga_out),     64'd0);
    check("rst_click_h", 64'(h_if.btn_click),   64'd0);
    check("rst_idx_h",   64'(h_if.click_idx),   64'd0);
    check("rst_hover_h", 64'(h_if.hover_valid), 64'd0);
    rst = 1'b0;
    tick();

    foreach (hv_tab[i]) begin
      mouse_x = hv_tab[i].x;
      mouse_y = hv_tab[i].y;
      tick();
      check($sformatf("hover%0d_valid_h", i), 64'(h_if.hover_valid), 64'(hv_tab[i].hv));
      check($sformatf("hover%0d_idx_h", i),   64'(h_if.hover_idx),   64'(hv_tab[i].hi));
      check($sformatf("hover%0d_valid_v", i), 64'(v_if.hover_valid), 64'(hv_tab[i].vv));
      check($sformatf("hover%0d_idx_v", i),   64'(v_if.hover_idx),   64'(hv_tab[i].vi));
    end

    move_to(12'd60, 12'd60);
    foreach (px_tab[i])
      show_pix($sformatf("pix%0d", i), px_tab[i].x, px_tab[i].y, px_tab[i].blank,
               px_tab[i].h_rgb, px_tab[i].v_rgb);

    // Hold left over button 0: fill turns to the pressed colour, border unchanged.
    mouse_left = 1'b1;
    repeat (3) tick();
    show_pix("press_fill",   11'd100, 11'd80, 1'b0, 12'h44F, 12'h44F);
    show_pix("press_border", 11'd50,  11'd50, 1'b0, 12'h000, 12'h000);
    show_pix("press_other",  11'd300, 11'd80, 1'b0, 12'h888, 12'h5A3);

    // Release latency: low first sampled at edge t, click visible after edge t+2 for one cycle.
    mouse_left = 1'b0;
    tick();
    check("lat_t0_h", 64'(h_if.btn_click), 64'd0);
    check("lat_t0_v", 64'(v_if.btn_click), 64'd0);
    tick();
    check("lat_t1_h", 64'(h_if.btn_click), 64'd0);
    check("lat_t1_v", 64'(v_if.btn_click), 64'd0);
    tick();
    check("lat_t2_h",   64'(h_if.btn_click), 64'b0001);
    check("lat_t2_v",   64'(v_if.btn_click), 64'b0001);
    check("lat_idx_h",  64'(h_if.click_idx), 64'd0);
    check("lat_idx_v",  64'(v_if.click_idx), 64'd0);
    tick();
    check("lat_t3_h", 64'(h_if.btn_click), 64'd0);
    check("lat_t3_v", 64'(v_if.btn_click), 64'd0);

    press_at(12'd60, 12'd60);
    move_to(12'd260, 12'd70);
    move_to(12'd60, 12'd60);
    expect_release("drag_back", 4'b0001, 4'b0001);

    press_at(12'd600, 12'd70);
    expect_release("click_h2", 4'b0100, 4'b0000);
    check("click_h2_idx_h", 64'(h_if.click_idx), 64'd2);
    check("click_h2_idx_v", 64'(v_if.click_idx), 64'd0);

    press_at(12'd100, 12'd220);
    expect_release("click_v2", 4'b0000, 4'b0100);
    check("click_v2_idx_v", 64'(v_if.click_idx), 64'd2);
    check("click_v2_idx_h", 64'(h_if.click_idx), 64'd2);

    press_at(12'd320, 12'd70);
    move_to(12'd600, 12'd70);
    expect_release("drag_off", 4'b0000, 4'b0000);
    check("drag_off_idx_h", 64'(h_if.click_idx), 64'd2);

    press_at(12'd260, 12'd70);
    move_to(12'd60, 12'd60);
    expect_release("gap_press", 4'b0000, 4'b0000);

    // Drop enable while armed on button 3.
    press_at(12'd710, 12'd70);
    show_pix("armed_b3", 11'd800, 11'd80, 1'b0, 12'h44F, 12'h5A3);
    enable = 1'b0;
    repeat (2) tick();
    check("dis_hover_valid_h", 64'(h_if.hover_valid), 64'd0);
    check("dis_hover_idx_h",   64'(h_if.hover_idx),   64'd0);
    show_pix("dis_pass", 11'd100, 11'd80, 1'b0, 12'h5A3, 12'h5A3);
    enable = 1'b1;
    repeat (2) tick();
    expect_release("en_drop", 4'b0000, 4'b0000);

    // Raise enable with the button already held: no arm.
    enable = 1'b0;
    mouse_x = 12'd60;
    mouse_y = 12'd60;
    tick();
    mouse_left = 1'b1;
    repeat (3) tick();
    enable = 1'b1;
    repeat (3) tick();
    show_pix("no_rearm", 11'd100, 11'd80, 1'b0, 12'hBBB, 12'hBBB);
    expect_release("en_rise", 4'b0000, 4'b0000);

    // Asynchronous reset while armed on button 2.
    press_at(12'd600, 12'd70);
    show_pix("armed_b2", 11'd600, 11'd80, 1'b0, 12'h44F, 12'h5A3);
    check("pre_rst_hover_idx_h", 64'(h_if.hover_idx), 64'd2);
    #2 rst = 1'b1;
    #1;
    check("arst_click_h", 64'(h_if.btn_click),   64'd0);
    check("arst_idx_h",   64'(h_if.click_idx),   64'd0);
    check("arst_hv_h",    64'(h_if.hover_valid), 64'd0);
    check("arst_hi_h",    64'(h_if.hover_idx),   64'd0);
    check("arst_vga_h",   64'(h_if.vga_out),     64'd0);
    check("arst_vga_v",   64'(v_if.vga_out),     64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) tick();
    expect_release("post_rst", 4'b0000, 4'b0000);

    press_at(12'd60, 12'd60);
    expect_release("recover", 4'b0001, 4'b0001);
    check("recover_idx_h", 64'(h_if.click_idx), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
